// File: rtl/ps2_pkg.sv
// Shared PS/2 scancode constants and types used by the key controller and
// any other consumer of the event FIFO.
package ps2_pkg;

  localparam logic [7:0] PS2_E0 = 8'hE0;
  localparam logic [7:0] PS2_F0 = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_E0   = 2'd1,
    S_F0   = 2'd2,
    S_E0F0 = 2'd3
  } ps2_state_e;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } ps2_event_t;

  // Keyboard status/acknowledge bytes that never represent a key when seen unprefixed.
  function automatic logic ps2_is_ignored(input logic [7:0] b);
    logic hit;
    case (b)
      8'h00, 8'hFF, 8'hFA, 8'hAA, 8'hEE, 8'hFE: hit = 1'b1;
      default:                                  hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// Byte-in / event-out channel of the PS/2 key controller.
interface ps2_key_ctrl_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_err;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_brk;

  modport master (
    output in_valid, in_data, in_err, ev_ready,
    input  ev_valid, ev_code, ev_ext, ev_brk
  );

  modport slave (
    input  in_valid, in_data, in_err, ev_ready,
    output ev_valid, ev_code, ev_ext, ev_brk
  );
endinterface

// File: rtl/ps2_event_fifo.sv
// Small synchronous event FIFO; a push into a full FIFO without a simultaneous
// pop is discarded. Output holds the last departed entry while empty.
module ps2_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok_s, pop_ok_s;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);
  assign dout  = empty ? last_q : mem_q[rd_ptr_q];

  // Next-state for pointers, occupancy and the held-on-empty copy of the head.
  always_comb begin
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
    if (push_ok_s) wr_ptr_d = wr_ptr_q + 1'b1;
    else           wr_ptr_d = wr_ptr_q;
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      last_d   = mem_q[rd_ptr_q];
    end else begin
      rd_ptr_d = rd_ptr_q;
      last_d   = last_q;
    end
    cnt_d = cnt_q + {{AW{1'b0}}, push_ok_s} - {{AW{1'b0}}, pop_ok_s};
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever observed.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// Turns the raw PS/2 scancode byte stream into make/break events, tracks the
// currently held key and counts distinct presses (typematic repeats excluded).
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int REPEAT_EN   = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  ps2_key_ctrl_if.slave        bus,
  output logic                 held_valid,
  output logic [7:0]           held_code,
  output logic                 held_ext,
  output logic [7:0]           press_cnt,
  output logic                 overflow,
  input  logic                 clr_ovf
);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  ps2_state_e  state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        held_valid_q, held_valid_d, held_ext_q, held_ext_d;
  logic [7:0]  held_code_q, held_code_d, cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        is_make_s, is_brk_s, ext_s, match_s, push_s, drop_s;
  logic        fifo_full_s, fifo_empty_s;
  ps2_event_t  ev_s, head_s;

  // Prefix tracking, prefix timeout, and held-key / press-count bookkeeping.
  always_comb begin
    state_d = state_q;
    tmo_d = tmo_q;
    held_valid_d = held_valid_q;
    held_code_d = held_code_q;
    held_ext_d = held_ext_q;
    cnt_d = cnt_q;
    is_make_s = 1'b0;
    is_brk_s = 1'b0;
    ext_s = 1'b0;
    push_s = 1'b0;
    if (bus.in_valid) begin
      tmo_d = '0;
      if (bus.in_err) begin
        state_d = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.in_data == PS2_E0)            state_d = S_E0;
            else if (bus.in_data == PS2_F0)       state_d = S_F0;
            else if (ps2_is_ignored(bus.in_data)) state_d = S_IDLE;
            else                                  is_make_s = 1'b1;
          end
          S_E0: begin
            if (bus.in_data == PS2_F0)      state_d = S_E0F0;
            else if (bus.in_data == PS2_E0) state_d = S_E0;
            else begin
              is_make_s = 1'b1;
              ext_s = 1'b1;
              state_d = S_IDLE;
            end
          end
          S_F0: begin
            if (bus.in_data == PS2_E0)      state_d = S_E0F0;
            else if (bus.in_data == PS2_F0) state_d = S_F0;
            else begin
              is_brk_s = 1'b1;
              state_d = S_IDLE;
            end
          end
          S_E0F0: begin
            state_d = S_IDLE;
            if (bus.in_data != PS2_E0 && bus.in_data != PS2_F0) begin
              is_brk_s = 1'b1;
              ext_s = 1'b1;
            end else begin
              is_brk_s = 1'b0;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end else if (state_q == S_IDLE) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      tmo_d = '0;
      state_d = S_IDLE;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    match_s = held_valid_q && (bus.in_data == held_code_q) && (ext_s == held_ext_q);
    if (is_make_s) begin
      if (match_s) begin
        push_s = (REPEAT_EN != 0);
      end else begin
        held_valid_d = 1'b1;
        held_code_d = bus.in_data;
        held_ext_d = ext_s;
        cnt_d = cnt_q + 8'd1;
        push_s = 1'b1;
      end
    end else if (is_brk_s) begin
      push_s = 1'b1;
      if (match_s) held_valid_d = 1'b0;
      else         held_valid_d = held_valid_q;
    end else begin
      push_s = 1'b0;
    end
    ev_s = '{brk: is_brk_s, ext: ext_s, code: bus.in_data};
  end

  // Sticky overflow; a drop in the same cycle as clr_ovf keeps it set.
  always_comb begin
    drop_s = push_s && fifo_full_s && !bus.ev_ready;
    if (drop_s)       ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      tmo_q <= '0;
      held_valid_q <= 1'b0;
      held_code_q <= 8'd0;
      held_ext_q <= 1'b0;
      cnt_q <= 8'd0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q <= tmo_d;
      held_valid_q <= held_valid_d;
      held_code_q <= held_code_d;
      held_ext_q <= held_ext_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(ps2_event_t))
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push_s),
    .din    (ev_s),
    .full   (fifo_full_s),
    .pop    (bus.ev_ready),
    .dout   (head_s),
    .empty  (fifo_empty_s)
  );

  assign bus.ev_valid = !fifo_empty_s;
  assign bus.ev_code  = head_s.code;
  assign bus.ev_ext   = head_s.ext;
  assign bus.ev_brk   = head_s.brk;
  assign held_valid   = held_valid_q;
  assign held_code    = held_code_q;
  assign held_ext     = held_ext_q;
  assign press_cnt    = cnt_q;
  assign overflow     = ovf_q;

endmodule

// File: doc/ps2_key_ctrl.md
Name: ps2_key_ctrl

Overview:
- Sequencing controller between the PS/2 frame receiver and the key-consumer logic (display, counters, LEDs).
- Consumes the raw scancode byte stream and tracks E0 (extended) and F0 (break) prefixes in a state machine.
- Emits decoded make/break key events through a small ready/valid FIFO.
- Maintains currently-held key state and a press counter that excludes typematic repeats.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; power of 2, minimum 2.
- TIMEOUT_CYC, 50000, clk cycles without a byte before a pending prefix is abandoned.
- REPEAT_EN, 0, 1 = typematic repeat makes are also pushed as events; 0 = repeats are suppressed.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- in_valid  in  1  one-cycle strobe: a frame byte was received.
- in_data  in  8  received byte; qualified by in_valid.
- in_err  in  1  qualified by in_valid: start, stop or parity error on this byte.
- ev_valid  out  1  FIFO non-empty.
- ev_ready  in  1  consumer accepts the head event when ev_valid && ev_ready.
- ev_code  out  8  head event scancode.
- ev_ext  out  1  head event is extended (E0-prefixed).
- ev_brk  out  1  head event is a break (release).
- held_valid  out  1  a key is currently held.
- held_code  out  8  code of the held key.
- held_ext  out  1  extended flag of the held key.
- press_cnt  out  8  count of distinct new key presses; wraps 255 -> 0.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- clr_ovf  in  1  clears overflow.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state = S_IDLE, FIFO empty, timeout counter = 0.
  - All outputs 0: ev_valid, ev_code, ev_ext, ev_brk, held_*, press_cnt, overflow.
- The input has no backpressure. Every in_valid byte is processed in its own cycle.
- in_valid with in_err=1: the byte is discarded, state goes to S_IDLE, and no event is generated.
- Byte classification is combinational from (state, in_data), with state updated at the edge. Transitions:
  - S_IDLE: E0 -> S_E0; F0 -> S_F0; 00/FF/FA/AA/EE/FE -> ignored, stay in S_IDLE; any other code -> make(ext=0).
  - S_E0: F0 -> S_E0F0; E0 -> stay in S_E0; any other code -> make(ext=1), then S_IDLE.
  - S_F0: E0 -> S_E0F0; F0 -> stay in S_F0; any other code -> break(ext=0), then S_IDLE.
  - S_E0F0: E0 or F0 -> discard, S_IDLE; any other code -> break(ext=1), then S_IDLE.
- Timeout:
  - The counter increments each cycle while state != S_IDLE and in_valid=0.
  - It clears on in_valid or while in S_IDLE.
  - When it reaches TIMEOUT_CYC-1, state -> S_IDLE and the counter clears.
  - If in_valid arrives on the expiry cycle, the byte wins: it is processed in the current state.
- Make handling:
  - A make that matches the held key (held_valid && code==held_code && ext==held_ext) is a repeat.
    - held_* and press_cnt are unchanged.
    - The event is pushed only if REPEAT_EN=1.
  - Any other make:
    - held_* <= {1, code, ext} (the new key replaces the held key).
    - press_cnt <= press_cnt+1.
    - The event is pushed.
- Break handling:
  - The event is always pushed.
  - If the break matches the held key, held_valid <= 0. Otherwise held_* is unchanged.
- Latency: an event pushed on in_valid in cycle N is visible as ev_valid=1 in cycle N+1 when the FIFO was empty.
- FIFO:
  - First-in first-out order. ev_* are driven from the head entry.
  - When empty, ev_code, ev_ext and ev_brk hold their last value; they are 0 after reset.
  - Pop occurs when ev_valid && ev_ready.
  - Push when full:
    - Without a simultaneous pop: the event is dropped and overflow <= 1.
    - With a simultaneous pop: both succeed and the occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH. The occupancy count is clog2(FIFO_DEPTH)+1 bits wide.
- overflow: clr_ovf clears it. If a set and clr_ovf occur in the same cycle, the set wins.

Decomposition:
- Package ps2_pkg contains:
  - Constants PS2_E0=8'hE0 and PS2_F0=8'hF0.
  - Ignored-code list.
  - State enum {S_IDLE, S_E0, S_F0, S_E0F0}.
  - Event type: 10 bits {brk, ext, code[7:0]}.
- One sub-module, ps2_event_fifo:
  - Parameterised on depth and width.
  - push/full and pop/empty interface with registered storage.
  - Drop on full push without pop.
  - Reused by other PS/2 consumers.

Test Plan:
- Bytes 1C, F0, 1C:
  - Events {make,ext0,1C} then {brk,ext0,1C}.
  - press_cnt=1.
  - held_valid goes 1 then 0.
- Bytes E0, 75, E0, F0, 75:
  - Events {make,ext1,75} then {brk,ext1,75}.
  - held_ext=1 while held.
- Bytes 1C, 1C, 1C with REPEAT_EN=0:
  - Exactly 1 event; press_cnt=1.
  - With REPEAT_EN=1: 3 events; press_cnt still 1.
- ev_ready=0, send 5 distinct makes (FIFO_DEPTH=4):
  - The first 4 are retained in order; overflow=1.
  - Raise ev_ready: 4 pops, then ev_valid=0.
  - Pulse clr_ovf: overflow=0.
- Byte E0, wait TIMEOUT_CYC cycles, then byte 1C:
  - Event {make,ext0,1C}, not extended.
- Mid-sequence cases:
  - Byte F0, then byte 1C with in_err=1, then byte 1C: a single make event, no break.
  - Assert resetn=0 in S_F0: all outputs 0, FIFO empty, state S_IDLE.
